// File: rtl/symbol_serializer.sv
// rtl/symbol_serializer.sv - framed byte to BPSK/QPSK symbol serializer
// One symbol per output beat, MSB first; frame mode and bit length latched at frame start.
module symbol_serializer #(
  parameter int BYTES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 is_bpsk,
  input  logic [12:0]          frame_len,
  input  logic [7:0]           S_tdata,
  input  logic                 S_tvalid,
  output logic                 S_tready,
  input  logic                 S_tlast,
  output logic [BYTES*8-1:0]   O_tdata,
  output logic                 O_tvalid,
  input  logic                 O_tready,
  output logic                 O_tlast,
  output logic                 O_tuser,
  output logic [15:0]          payload_length,
  output logic                 len_err
);

  localparam int BITS = BYTES * 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        shreg_q;
  logic [2:0]        sym_idx_q;
  logic              byte_last_q;
  logic              frame_start_q;
  logic [12:0]       byte_cnt_q;
  logic [12:0]       frame_len_q;
  logic [BITS-1:0]   o_tdata_q;
  logic              o_tlast_q;
  logic              tuser_q;
  logic [15:0]       payload_length_q;
  logic              len_err_q;

  logic              sym_last;
  logic [2:0]        last_idx;
  logic [2:0]        idx_next;
  logic              s_hs;
  logic              out_hs;
  logic              mode_n;
  logic [12:0]       cnt_base;
  logic [12:0]       len_base;
  logic [13:0]       cnt_plus1;
  logic [12:0]       cnt_next;

  // Symbol k of byte b: BPSK replicates bit 7-k, QPSK places bits 7-2k:6-2k in [1:0].
  function automatic logic [BITS-1:0] sym_word(input logic [7:0] b, input logic [2:0] k,
                                               input logic bpsk);
    logic [7:0] sh;
    sh = b << (bpsk ? k : {k[1:0], 1'b0});
    if (bpsk) return {BITS{sh[7]}};
    return {{(BITS-2){1'b0}}, sh[7:6]};
  endfunction

  always_comb begin
    last_idx  = tuser_q ? 3'd7 : 3'd3;
    sym_last  = (sym_idx_q == last_idx);
    idx_next  = sym_idx_q + 3'd1;
    S_tready  = (state_q == IDLE) | ((state_q == SHIFT) & sym_last & O_tready);
    s_hs      = S_tvalid & S_tready;
    out_hs    = (state_q == SHIFT) & O_tready;
    // A frame-start byte sees the live mode/length and a cleared count.
    mode_n    = frame_start_q ? is_bpsk : tuser_q;
    cnt_base  = frame_start_q ? 13'd0 : byte_cnt_q;
    len_base  = frame_start_q ? frame_len : frame_len_q;
    cnt_plus1 = {1'b0, cnt_base} + 14'd1;
    cnt_next  = cnt_plus1[13] ? 13'h1fff : cnt_plus1[12:0];
  end

  always_comb begin
    state_d = state_q;
    if (s_hs) begin
      state_d = SHIFT;
    end else if (out_hs && sym_last) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q          <= '0;
      sym_idx_q        <= '0;
      byte_last_q      <= 1'b0;
      frame_start_q    <= 1'b1;
      byte_cnt_q       <= '0;
      frame_len_q      <= '0;
      o_tdata_q        <= '0;
      o_tlast_q        <= 1'b0;
      tuser_q          <= 1'b1;
      payload_length_q <= '0;
      len_err_q        <= 1'b0;
    end else if (s_hs) begin
      shreg_q       <= S_tdata;
      sym_idx_q     <= '0;
      byte_last_q   <= S_tlast;
      frame_start_q <= S_tlast;
      byte_cnt_q    <= cnt_next;
      o_tdata_q     <= sym_word(S_tdata, 3'd0, mode_n);
      o_tlast_q     <= 1'b0;
      if (frame_start_q) begin
        tuser_q          <= is_bpsk;
        frame_len_q      <= frame_len;
        payload_length_q <= {frame_len, 3'b000};
      end
      if (S_tlast) begin
        len_err_q <= (cnt_plus1 != {1'b0, len_base});
      end else if (frame_start_q) begin
        len_err_q <= 1'b0;
      end
    end else if (out_hs && !sym_last) begin
      sym_idx_q <= idx_next;
      o_tdata_q <= sym_word(shreg_q, idx_next, tuser_q);
      o_tlast_q <= byte_last_q && (idx_next == last_idx);
    end else if (out_hs) begin
      o_tlast_q <= 1'b0;
    end
  end

  assign O_tvalid       = (state_q == SHIFT);
  assign O_tdata        = o_tdata_q;
  assign O_tlast        = o_tlast_q;
  assign O_tuser        = tuser_q;
  assign payload_length = payload_length_q;
  assign len_err        = len_err_q;

endmodule

// File: tb/tb_symbol_serializer.sv
// tb/tb_symbol_serializer.sv - scoreboard bench for symbol_serializer
// Expected symbols are queued at each byte handshake; a negedge monitor pops and compares.
module tb_symbol_serializer;

  localparam int BYTES = 1;
  localparam int BITS  = BYTES * 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             is_bpsk = 1'b1;
  logic [12:0]      frame_len = '0;
  logic [7:0]       S_tdata = '0;
  logic             S_tvalid = 1'b0;
  logic             S_tready;
  logic             S_tlast = 1'b0;
  logic [BITS-1:0]  O_tdata;
  logic             O_tvalid;
  logic             O_tready = 1'b1;
  logic             O_tlast;
  logic             O_tuser;
  logic [15:0]      payload_length;
  logic             len_err;

  typedef struct {
    logic [7:0]  data;
    bit          last;
    bit          user;
    logic [15:0] plen;
    bit          lerr;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  logic [7:0] txb[$];
  int         beat_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         beats = 0;
  bit         rdy_rand = 1'b0;

  symbol_serializer #(.BYTES(BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .is_bpsk(is_bpsk), .frame_len(frame_len),
    .S_tdata(S_tdata), .S_tvalid(S_tvalid), .S_tready(S_tready), .S_tlast(S_tlast),
    .O_tdata(O_tdata), .O_tvalid(O_tvalid), .O_tready(O_tready), .O_tlast(O_tlast),
    .O_tuser(O_tuser), .payload_length(payload_length), .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) O_tready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst_n && O_tvalid && O_tready) begin
      beats++;
      beat_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        chk("unexpected_beat", 32'(O_tdata), 32'hDEAD);
      end else begin
        mon_e = expq.pop_front();
        chk("tdata", 32'(O_tdata), 32'(mon_e.data));
        chk("tlast", 32'(O_tlast), 32'(mon_e.last));
        chk("tuser", 32'(O_tuser), 32'(mon_e.user));
        chk("payload_length", 32'(payload_length), 32'(mon_e.plen));
        chk("len_err", 32'(len_err), 32'(mon_e.lerr));
      end
    end
  end

  // Reference: 8 one-bit symbols or 4 two-bit symbols per byte, MSB first.
  task automatic push_byte(input logic [7:0] b, input bit bpsk, input bit last,
                           input logic [15:0] plen, input bit lerr);
    int   ns;
    exp_t e;
    ns = bpsk ? 8 : 4;
    for (int k = 0; k < ns; k++) begin
      if (bpsk) e.data = b[7-k] ? 8'hFF : 8'h00;
      else      e.data = (b >> (6 - 2 * k)) & 8'h03;
      e.last = last && (k == ns - 1);
      e.user = bpsk;
      e.plen = plen;
      e.lerr = lerr;
      expq.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic send_frame(input bit bpsk, input logic [12:0] fl, input bit gaps);
    int n;
    int t;
    n = txb.size();
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (i == 0) begin
        is_bpsk   = bpsk;
        frame_len = fl;
      end else begin
        is_bpsk   = 1'($urandom);
        frame_len = 13'($urandom);
      end
      S_tdata  = txb[i];
      S_tlast  = (i == n - 1);
      S_tvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!S_tready && t < 500);
      if (!S_tready) chk("s_accept_timeout", 32'd0, 32'd1);
      else push_byte(txb[i], bpsk, i == n - 1, {fl, 3'b000}, (i == n - 1) && (n != int'(fl)));
      @(posedge clk); #1;
      S_tvalid = 1'b0;
      S_tlast  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    chk("drain_left", 32'(expq.size()), 32'd0);
    @(negedge clk);
    chk("idle_tvalid", 32'(O_tvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_gapfree(input string name, input int n);
    chk({name, "_beats"}, 32'(beat_cyc.size()), 32'(n));
    if (beat_cyc.size() == n)
      chk({name, "_span"}, 32'(beat_cyc[n-1] - beat_cyc[0]), 32'(n - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d expected=done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    int t;
    int n;
    bit bp;
    logic [12:0] fl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(O_tvalid), 32'd0);
    chk("rst_tdata", 32'(O_tdata), 32'd0);
    chk("rst_tlast", 32'(O_tlast), 32'd0);
    chk("rst_tuser", 32'(O_tuser), 32'd1);
    chk("rst_plen", 32'(payload_length), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_s_tready", 32'(S_tready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    txb = '{8'hA5};
    beat_cyc.delete();
    send_frame(1'b1, 13'd1, 1'b0);
    wait_drain();
    chk_gapfree("bpsk_a5", 8);

    txb = '{8'h1B, 8'hE4};
    beat_cyc.delete();
    send_frame(1'b0, 13'd2, 1'b0);
    wait_drain();
    chk_gapfree("qpsk_pair", 8);

    // Stall beat 0 for three cycles.
    O_tready = 1'b0;
    is_bpsk = 1'b1; frame_len = 13'd1; S_tdata = 8'h80; S_tlast = 1'b1; S_tvalid = 1'b1;
    push_byte(8'h80, 1'b1, 1'b1, 16'd8, 1'b0);
    @(posedge clk); #1;
    S_tvalid = 1'b0; S_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_tvalid", 32'(O_tvalid), 32'd1);
      chk("stall_tdata", 32'(O_tdata), 32'hFF);
      chk("stall_s_tready", 32'(S_tready), 32'd0);
      @(posedge clk); #1;
    end
    O_tready = 1'b1;
    wait_drain();

    txb = '{8'h3C, 8'hC3};
    send_frame(1'b1, 13'd3, 1'b0);
    wait_drain();
    chk("mismatch_sticky", 32'(len_err), 32'd1);
    txb = '{8'h5A};
    send_frame(1'b1, 13'd1, 1'b0);
    wait_drain();
    chk("mismatch_cleared", 32'(len_err), 32'd0);

    txb = '{8'h96};
    send_frame(1'b0, 13'd0, 1'b0);
    wait_drain();
    chk("zero_len_err", 32'(len_err), 32'd1);

    rdy_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      n  = $urandom_range(1, 4);
      bp = 1'($urandom);
      fl = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 5)) : 13'(n);
      txb.delete();
      for (int i = 0; i < n; i++) txb.push_back(8'($urandom));
      send_frame(bp, fl, 1'b1);
    end
    wait_drain();
    rdy_rand = 1'b0;
    @(posedge clk); #1;
    O_tready = 1'b1;

    // Reset in the middle of a byte.
    b0 = beats;
    is_bpsk = 1'b1; frame_len = 13'd1; S_tdata = 8'hA5; S_tlast = 1'b1; S_tvalid = 1'b1;
    push_byte(8'hA5, 1'b1, 1'b1, 16'd8, 1'b0);
    @(posedge clk); #1;
    S_tvalid = 1'b0; S_tlast = 1'b0;
    t = 0;
    while (beats < b0 + 3 && t < 50) begin @(negedge clk); t++; end
    chk("pre_reset_beats", 32'(beats >= b0 + 3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(O_tvalid), 32'd0);
    chk("async_rst_tuser", 32'(O_tuser), 32'd1);
    chk("async_rst_plen", 32'(payload_length), 32'd0);
    expq.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    txb = '{8'hFF};
    beat_cyc.delete();
    send_frame(1'b1, 13'd5, 1'b0);
    wait_drain();
    chk_gapfree("post_reset", 8);
    chk("post_reset_plen", 32'(payload_length), 32'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_serializer.md
Name: symbol_serializer

Overview:
- Byte-to-symbol serializer feeding the packetizer's payload AXIS input (I_tdata/I_tvalid/I_tready/I_tlast/I_tuser).
- Splits framed payload bytes into one symbol per output beat: 1 bit/symbol for BPSK, 2 bits/symbol for QPSK.
- Tags every symbol with the frame's modulation and drives payload_length in bits.
- Output runs gap-free while the byte source keeps up, so the packetizer's payload stream has no bubbles.

Parameters:
- BYTES, 1, output tdata width in bytes (BITS = BYTES*8, at least 1).

Ports:
- clk  in  1  symbol-rate clock (same slow clock as the packetizer)
- rst_n  in  1  asynchronous active-low reset
- is_bpsk  in  1  modulation for the next frame; 1 = BPSK, 0 = QPSK; sampled with the frame's first byte
- frame_len  in  13  frame length in bytes; sampled with the frame's first byte
- S_tdata  in  8  payload byte
- S_tvalid  in  1  byte valid
- S_tready  out  1  byte accepted when S_tvalid & S_tready
- S_tlast  in  1  last byte of frame
- O_tdata  out  BITS  symbol word
- O_tvalid  out  1  symbol valid
- O_tready  in  1  downstream ready
- O_tlast  out  1  last symbol of frame
- O_tuser  out  1  is_bpsk of the current frame
- payload_length  out  16  frame length in bits
- len_err  out  1  sticky length-mismatch flag for the last completed frame

Behaviour:
- Reset (asynchronous, rst_n=0): O_tvalid=0, O_tdata=0, O_tlast=0, O_tuser=1, payload_length=0, len_err=0, byte count=0, symbol index=0, state=IDLE. Any partial byte or frame is discarded. The first S handshake after rst_n rises is treated as a frame start.
- States:
  - IDLE: no byte held, O_tvalid=0.
  - SHIFT: byte held, symbols being emitted.
- S_tready = (state==IDLE) | (state==SHIFT & last symbol of the held byte & O_tready). This is the only combinational path (O_tready -> S_tready); it gives gap-free reload.
- Byte accept: on S handshake, load the shift register, latch S_tlast with the byte, reset symbol index to 0, and go to SHIFT. O_tvalid=1 and symbol 0 are registered in the same edge, so latency from S handshake to first O_tvalid is 1 cycle.
- Frame start (first byte after reset or after a byte flagged S_tlast):
  - latch is_bpsk into O_tuser;
  - payload_length = {frame_len, 3'b000};
  - clear byte count and len_err.
  - payload_length and O_tuser then hold until the next frame start. Downstream samples them while the frame's symbols are in flight.
- Symbol mapping, MSB first:
  - BPSK, 8 symbols/byte: symbol k has O_tdata = {BITS{byte[7-k]}}.
  - QPSK, 4 symbols/byte: symbol k has O_tdata[1:0] = byte[7-2k -: 2], upper bits 0.
- Advance: on O_tvalid & O_tready, increment the symbol index. After the last symbol (index 7 for BPSK, 3 for QPSK):
  - if S_tvalid, load the next byte in the same edge;
  - otherwise return to IDLE (O_tvalid=0).
- Backpressure: while O_tvalid & !O_tready, O_tdata/O_tlast/O_tuser hold stable and S_tready=0.
- O_tlast=1 only on the last symbol of a byte that arrived with S_tlast.
- Byte counter: 13-bit, saturating at 8191, incremented per accepted byte.
- Length check, at the byte carrying S_tlast: len_err <= (count+1 != frame_len). len_err holds until the next frame start. Mismatch never truncates or extends the output; S_tlast alone ends the frame.
- frame_len=0 with a data byte: the byte is still serialized and len_err=1.
- Mode change mid-frame: is_bpsk is ignored until the next frame start.

Test Plan:
- BPSK single byte 0xA5, S_tlast=1, frame_len=1, O_tready=1 -> 8 consecutive beats with O_tdata = FF,00,FF,00,00,FF,00,FF; O_tlast only on beat 8; O_tuser=1; payload_length=8; len_err=0.
- QPSK bytes 0x1B, 0xE4 back-to-back, frame_len=2 -> 8 gap-free beats with O_tdata[1:0] = 0,1,2,3,3,2,1,0; O_tuser=0; payload_length=16; O_tvalid never drops between the bytes.
- Backpressure: BPSK 0x80 with O_tready low for 3 cycles on beat 0 -> O_tdata=FF held for 4 cycles, S_tready=0 throughout, then 7 beats of 00.
- Length mismatch: frame_len=3, only 2 bytes with S_tlast on byte 2 -> 16 BPSK symbols, O_tlast on symbol 16, len_err=1; next frame with a correct length clears it at frame start.
- Mode switch: BPSK frame, then a QPSK frame with is_bpsk toggled mid-first-frame -> first frame O_tuser=1 throughout, second frame O_tuser=0 from its first symbol.
- Reset mid-byte: assert rst_n=0 after 3 symbols -> O_tvalid=0 immediately (asynchronous); after release, a new byte 0xFF yields 8 fresh symbols and payload_length is taken from the new frame_len.
